signal_measure_avg: RTL and testbench

Parametrised successor to the single-period signal measurement controller. On an `enable` pulse it synchronises `sig_in`, then measures high and low durations over 2^`avg_sel` consecutive periods. From the accumulated counts it computes averaged high/low time, frequency in Hz and duty in percent using one shared sequential divider. A no-edge timeout aborts stalled measurements. It sits between a raw digital input pin and the register or display logic that reads the results.

---
 rtl/signal_measure_pkg.sv | 32 +++
 rtl/seq_divider.sv | 63 ++++++
 rtl/signal_measure_avg.sv | 230 +++++++++++++++++++++++
 tb/tb_signal_measure_avg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/signal_measure_pkg.sv
// rtl/signal_measure_pkg.sv - shared types, constants and width helpers for signal_measure_avg
package signal_measure_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DIV_F,
        ST_DIV_D,
        ST_DONE
    } state_t;

    // Duty is reported in percent; 100 needs 7 bits when multiplied into the accumulator.
    localparam int DUTY_SCALE   = 100;
    localparam int DUTY_SCALE_W = 7;

    // Quotient bits of the shared divider, enough for CLK_FREQ << MAX_AVG_LOG2.
    function automatic int div_width(input int clk_freq, input int max_avg_log2);
        return $clog2(clk_freq) + max_avg_log2;
    endfunction

    // Accumulator width: per-period counter width plus room for 2^MAX_AVG_LOG2 periods of high+low.
    function automatic int acc_width(input int cnt_w, input int max_avg_log2);
        return cnt_w + max_avg_log2 + 1;
    endfunction

    // Width of the avg_sel input, never narrower than one bit.
    function automatic int sel_width(input int max_avg_log2);
        return ($clog2(max_avg_log2 + 1) > 0) ? $clog2(max_avg_log2 + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring sequential divider, one load cycle then one quotient bit per cycle
module seq_divider #(
    parameter int WIDTH = 30,
    parameter int DVD_W = 32,
    parameter int DSR_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Dividend bits above WIDTH preload the remainder; the caller guarantees they are
    // smaller than the divisor so the quotient still fits in WIDTH bits.
    logic [DSR_W-1:0] rem;
    logic [DSR_W-1:0] dsr;
    logic [WIDTH-1:0] dvd_lo;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [DSR_W:0]   trial;
    logic             fits;

    assign trial = {rem, dvd_lo[WIDTH-1]};
    assign fits  = (trial >= {1'b0, dsr});

    // Load operands on start, then shift in one dividend bit and resolve one quotient bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsr      <= '0;
            dvd_lo   <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= DSR_W'(dividend >> WIDTH);
                dsr      <= divisor;
                dvd_lo   <= dividend[WIDTH-1:0];
                quotient <= '0;
                cnt      <= CNT_W'(WIDTH);
                running  <= 1'b1;
            end else if (running) begin
                rem      <= fits ? DSR_W'(trial - {1'b0, dsr}) : DSR_W'(trial);
                quotient <= {quotient[WIDTH-2:0], fits};
                dvd_lo   <= dvd_lo << 1;
                cnt      <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/signal_measure_avg.sv
// rtl/signal_measure_avg.sv - averaged high/low time, frequency and duty measurement of an async input
module signal_measure_avg
    import signal_measure_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int CNT_W        = 20,
    parameter int FREQ_W       = 26,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int TIMEOUT_CYC  = 1_000_000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [sel_width(MAX_AVG_LOG2)-1:0]   avg_sel,
    input  logic                                 sig_in,
    output logic                                 busy,
    output logic                                 finish,
    output logic                                 timeout,
    output logic [FREQ_W-1:0]                    freq,
    output logic [7:0]                           duty,
    output logic [CNT_W-1:0]                     high_time,
    output logic [CNT_W-1:0]                     low_time
);

    localparam int SEL_W      = sel_width(MAX_AVG_LOG2);
    localparam int DIV_W      = div_width(CLK_FREQ, MAX_AVG_LOG2);
    localparam int ACC_W      = acc_width(CNT_W, MAX_AVG_LOG2);
    localparam int PER_W      = MAX_AVG_LOG2 + 1;
    localparam int DUTY_DVD_W = ACC_W + DUTY_SCALE_W;
    localparam int DVD_W      = (DIV_W > DUTY_DVD_W) ? DIV_W : DUTY_DVD_W;
    localparam int QW         = (DIV_W > FREQ_W) ? DIV_W : FREQ_W;

    state_t state, state_next;

    logic             sync_1, sync_2, sync_3;
    logic             level, rise, any_edge;
    logic [ACC_W-1:0] hi_acc, lo_acc;
    logic [ACC_W-1:0] hi_avg, lo_avg;
    logic [PER_W-1:0] per_cnt, per_total;
    logic             last_period;
    logic [CNT_W-1:0] idle_cnt;
    logic             counting, timed_out;
    logic [SEL_W-1:0] sel_q;
    logic [FREQ_W-1:0] freq_res;

    logic             div_start, div_done;
    logic [DVD_W-1:0] div_dividend;
    logic [ACC_W-1:0] div_divisor;
    logic [DIV_W-1:0] div_quotient;
    logic [QW-1:0]    quo_ext;

    // Two-flop synchroniser plus one delay stage for edge detection; both edges share the same delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= sig_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign level    = sync_2;
    assign rise     = sync_2 & ~sync_3;
    assign any_edge = sync_2 ^ sync_3;

    assign per_total   = PER_W'(1) << sel_q;
    assign last_period = ((per_cnt + PER_W'(1)) == per_total);
    assign counting    = (state == ST_ARM) || (state == ST_MEASURE);
    assign timed_out   = counting && !any_edge && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    assign hi_avg  = hi_acc >> sel_q;
    assign lo_avg  = lo_acc >> sel_q;
    assign quo_ext = QW'(div_quotient);

    assign busy   = (state != ST_IDLE);
    assign finish = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; also launches each divide on the cycle that leaves the preceding state.
    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (timed_out) begin
                    state_next = ST_DONE;
                end else if (rise) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (timed_out) begin
                    state_next = ST_DONE;
                end else if (rise && last_period) begin
                    state_next = ST_DIV_F;
                    div_start  = 1'b1;
                end
            end
            ST_DIV_F: begin
                if (div_done) begin
                    state_next = ST_DIV_D;
                    div_start  = 1'b1;
                end
            end
            ST_DIV_D: begin
                if (div_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Divider operands: frequency is launched from MEASURE, duty is launched from DIV_F.
    always_comb begin
        div_dividend = DVD_W'(CLK_FREQ) << sel_q;
        if (state == ST_DIV_F) begin
            div_dividend = DVD_W'(hi_acc) * DVD_W'(DUTY_SCALE);
        end
    end

    assign div_divisor = hi_acc + lo_acc;

    seq_divider #(
        .WIDTH (DIV_W),
        .DVD_W (DVD_W),
        .DSR_W (ACC_W)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // Accumulation, timeout supervision and result loading; outputs change only when a run ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_acc    <= '0;
            lo_acc    <= '0;
            per_cnt   <= '0;
            idle_cnt  <= '0;
            sel_q     <= '0;
            freq_res  <= '0;
            timeout   <= 1'b0;
            freq      <= '0;
            duty      <= '0;
            high_time <= '0;
            low_time  <= '0;
        end else begin
            if (counting) begin
                idle_cnt <= any_edge ? '0 : idle_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        hi_acc   <= '0;
                        lo_acc   <= '0;
                        per_cnt  <= '0;
                        idle_cnt <= '0;
                        timeout  <= 1'b0;
                        sel_q    <= (avg_sel > SEL_W'(MAX_AVG_LOG2)) ? SEL_W'(MAX_AVG_LOG2) : avg_sel;
                    end
                end
                ST_ARM, ST_MEASURE: begin
                    if (timed_out) begin
                        timeout   <= 1'b1;
                        freq      <= '0;
                        duty      <= '0;
                        high_time <= '0;
                        low_time  <= '0;
                    end else if (state == ST_ARM) begin
                        // The start edge cycle is the first high cycle of period one.
                        if (rise) begin
                            hi_acc <= hi_acc + 1'b1;
                        end
                    end else if (!(rise && last_period)) begin
                        if (rise) begin
                            per_cnt <= per_cnt + 1'b1;
                        end
                        if (level) begin
                            hi_acc <= hi_acc + 1'b1;
                        end else begin
                            lo_acc <= lo_acc + 1'b1;
                        end
                    end
                end
                ST_DIV_F: begin
                    if (div_done) begin
                        freq_res <= (|(quo_ext >> FREQ_W)) ? '1 : quo_ext[FREQ_W-1:0];
                    end
                end
                ST_DIV_D: begin
                    if (div_done) begin
                        freq      <= freq_res;
                        duty      <= div_quotient[7:0];
                        high_time <= (|(hi_avg >> CNT_W)) ? '1 : hi_avg[CNT_W-1:0];
                        low_time  <= (|(lo_avg >> CNT_W)) ? '1 : lo_avg[CNT_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signal_measure_avg.sv
// tb/tb_signal_measure_avg.sv - directed self-checking bench for signal_measure_avg
module tb_signal_measure_avg;

    localparam int TIMEOUT_CYC = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  avg_sel;
    logic        sig_in;
    logic        busy;
    logic        finish;
    logic        timeout;
    logic [25:0] freq;
    logic [7:0]  duty;
    logic [19:0] high_time;
    logic [19:0] low_time;

    int errors = 0;
    int checks = 0;

    int gen_hi0 = 40;
    int gen_lo0 = 60;
    int gen_hi1 = 40;
    int gen_lo1 = 60;
    bit gen_on  = 1'b0;

    signal_measure_avg #(
        .CLK_FREQ     (50_000_000),
        .CNT_W        (20),
        .FREQ_W       (26),
        .MAX_AVG_LOG2 (4),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .avg_sel   (avg_sel),
        .sig_in    (sig_in),
        .busy      (busy),
        .finish    (finish),
        .timeout   (timeout),
        .freq      (freq),
        .duty      (duty),
        .high_time (high_time),
        .low_time  (low_time)
    );

    always #10 clk = ~clk;

    initial begin
        sig_in = 1'b0;
        forever begin
            if (gen_on) begin
                sig_in = 1'b1; repeat (gen_hi0) @(negedge clk);
                sig_in = 1'b0; repeat (gen_lo0) @(negedge clk);
                sig_in = 1'b1; repeat (gen_hi1) @(negedge clk);
                sig_in = 1'b0; repeat (gen_lo1) @(negedge clk);
            end else begin
                sig_in = 1'b0;
                @(negedge clk);
            end
        end
    end

    task automatic set_gen(input int h0, input int l0, input int h1, input int l1, input bit on);
        gen_hi0 = h0; gen_lo0 = l0; gen_hi1 = h1; gen_lo1 = l1; gen_on = on;
        repeat (450) @(negedge clk);
    endtask

    task automatic start_meas(input logic [2:0] sel);
        @(negedge clk);
        enable  = 1'b1;
        avg_sel = sel;
        @(negedge clk);
        enable  = 1'b0;
    endtask

    task automatic wait_finish(input int budget, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            if (finish === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; avg_sel = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, finish, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, finish, timeout}); end
        checks++; if (freq !== 26'd0 || duty !== 8'd0) begin errors++; $display("FAIL reset_freq_duty: got %0d/%0d expected 0/0", freq, duty); end
        checks++; if (high_time !== 20'd0 || low_time !== 20'd0) begin errors++; $display("FAIL reset_times: got %0d/%0d expected 0/0", high_time, low_time); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_measure(input string name, input int h0, input int l0, input int h1, input int l1,
                                input logic [2:0] sel, input int e_high, input int e_low,
                                input int e_freq, input int e_duty);
        int  cyc;
        bit  seen;
        set_gen(h0, l0, h1, l1, 1'b1);
        start_meas(sel);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b expected 1", name, busy); end
        wait_finish(4000, cyc, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s finish: got none in %0d cycles expected a pulse", name, cyc);
        end else begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_finish: got %b expected 1", name, busy); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s timeout: got %b expected 0", name, timeout); end
            checks++; if (high_time !== 20'(e_high)) begin errors++; $display("FAIL %s high_time: got %0d expected %0d", name, high_time, e_high); end
            checks++; if (low_time !== 20'(e_low)) begin errors++; $display("FAIL %s low_time: got %0d expected %0d", name, low_time, e_low); end
            checks++; if (freq !== 26'(e_freq)) begin errors++; $display("FAIL %s freq: got %0d expected %0d", name, freq, e_freq); end
            checks++; if (duty !== 8'(e_duty)) begin errors++; $display("FAIL %s duty: got %0d expected %0d", name, duty, e_duty); end
            @(negedge clk);
            checks++; if (busy !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL %s after_finish: got busy=%b finish=%b expected 0 0", name, busy, finish); end
        end
    endtask

    task automatic test_timeout;
        int cyc;
        bit seen;
        set_gen(40, 60, 40, 60, 1'b0);
        start_meas(3'd0);
        wait_finish(2000, cyc, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL timeout_finish: got none in %0d cycles expected a pulse", cyc);
        end else begin
            checks++; if (cyc < 995 || cyc > 1005) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected about 1000", cyc); end
            checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", timeout); end
            checks++; if (freq !== 26'd0 || duty !== 8'd0) begin errors++; $display("FAIL timeout_freq_duty: got %0d/%0d expected 0/0", freq, duty); end
            checks++; if (high_time !== 20'd0 || low_time !== 20'd0) begin errors++; $display("FAIL timeout_times: got %0d/%0d expected 0/0", high_time, low_time); end
        end
        repeat (5) @(negedge clk);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %b expected 1", timeout); end
        set_gen(40, 60, 40, 60, 1'b1);
        start_meas(3'd0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
        wait_finish(4000, cyc, seen);
        checks++; if (!seen || freq !== 26'd500000) begin errors++; $display("FAIL timeout_recover_freq: got %0d expected 500000", freq); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit seen;
        set_gen(40, 60, 40, 60, 1'b1);
        start_meas(3'd0);
        repeat (10) @(negedge clk);
        enable = 1'b1; avg_sel = 3'd3;
        @(negedge clk);
        enable = 1'b0;
        wait_finish(4000, cyc, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL b2b_finish: got none in %0d cycles expected a pulse", cyc);
        end else begin
            checks++; if (freq !== 26'd500000 || high_time !== 20'd40) begin errors++; $display("FAIL b2b_no_restart: got freq=%0d high=%0d expected 500000 40", freq, high_time); end
            enable = 1'b1; avg_sel = 3'd0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL b2b_enable_on_finish: got busy=%b finish=%b expected 0 0", busy, finish); end
            @(negedge clk);
            enable = 1'b0;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_first_idle_accept: got %b expected 1", busy); end
            wait_finish(4000, cyc, seen);
            checks++; if (!seen || duty !== 8'd40 || low_time !== 20'd60) begin errors++; $display("FAIL b2b_second_run: got duty=%0d low=%0d expected 40 60", duty, low_time); end
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        bit seen;
        set_gen(40, 60, 40, 60, 1'b1);
        start_meas(3'd4);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, finish, timeout} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", {busy, finish, timeout}); end
        checks++; if (freq !== 26'd0 || duty !== 8'd0 || high_time !== 20'd0 || low_time !== 20'd0) begin
            errors++; $display("FAIL abort_outputs: got %0d/%0d/%0d/%0d expected all 0", freq, duty, high_time, low_time);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_finish(2500, cyc, seen);
        checks++; if (seen) begin errors++; $display("FAIL abort_no_finish: got a pulse after %0d cycles expected none", cyc); end
        start_meas(3'd0);
        wait_finish(4000, cyc, seen);
        checks++; if (!seen || high_time !== 20'd40 || freq !== 26'd500000) begin errors++; $display("FAIL abort_recover: got high=%0d freq=%0d expected 40 500000", high_time, freq); end
    endtask

    initial begin
        test_reset();
        test_measure("p2000_d40_sel0", 40, 60, 40, 60, 3'd0, 40, 60, 500000, 40);
        test_measure("p1000_d50_sel3", 25, 25, 25, 25, 3'd3, 25, 25, 1000000, 50);
        test_measure("alt_100_102_sel1", 50, 50, 51, 51, 3'd1, 50, 50, 495049, 50);
        test_measure("clamp_sel7", 40, 60, 40, 60, 3'd7, 40, 60, 500000, 40);
        test_measure("p30_d20_sel2", 6, 24, 6, 24, 3'd2, 6, 24, 1666666, 20);
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
